inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Instruction queue between instruction fetch and the ID (decode/issue) stage.
- Buffers fetched {inst, pc, branch-prediction bit} entries in a circular FIFO.
- Presents the head entry combinationally (show-ahead) so ID can decode it, decide stall/issue in the same cycle, and pop it with its read enable.
- Flushed by `clear` on branch misprediction.

Parameters:
- DEPTH, 16, number of entries; must be a power of two, at least 2.
- PTR_W, 4, log2(DEPTH); width of the head and tail pointers.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- rdy  input  1  global ready; when low, all state freezes (except `clear`).
- clear  input  1  synchronous flush on misprediction.
- if_we_i  input  1  fetch push request.
- if_inst_i  input  32  fetched instruction (`InstBus`).
- if_pc_i  input  32  pc of the fetched instruction (`AddrBus`).
- if_bp_i  input  1  predicted-taken bit for the fetched instruction.
- iq_full_o  output  1  queue full; fetch must hold its push while this is high.
- id_re_i  input  1  pop request from ID, driven combinationally from the head outputs.
- inst_o  output  32  head instruction.
- pc_o  output  32  head pc.
- bp_o  output  1  head prediction bit.
- iq_empty_o  output  1  `Empty` (1'b1) when the queue holds no entries.

Behaviour:
- Storage:
  - Array of DEPTH entries, 65 bits each.
  - head and tail pointers, PTR_W bits, wrap modulo DEPTH.
  - count, PTR_W+1 bits, range 0..DEPTH.
  - Storage contents are not reset.
- Reset (async, rst=1):
  - head=0, tail=0, count=0.
  - Outputs: iq_empty_o=1, iq_full_o=0, inst_o=0, pc_o=0, bp_o=0.
- Flag outputs (combinational):
  - iq_empty_o = (count==0).
  - iq_full_o = (count==DEPTH).
- Head outputs (combinational):
  - When not empty, inst_o/pc_o/bp_o = entry[head].
  - When empty, they are forced to `Null` (0).
  - There is no bypass: a pushed entry becomes visible at the head the cycle after the push.
- Update priority at each posedge: rst (async) > clear > !rdy > normal operation.
- clear=1: head=0, tail=0, count=0. Any push or pop in the same cycle is discarded. clear takes effect even when rdy=0.
- rdy=0 and clear=0: no state change; pushes and pops are ignored.
- Push accepted iff if_we_i && !iq_full_o:
  - entry[tail] <= {if_inst_i, if_pc_i, if_bp_i}; tail <= tail+1.
  - A push while full is dropped. It is not accepted even if a pop occurs in the same cycle; acceptance depends on the pre-edge full flag.
- Pop accepted iff id_re_i && !iq_empty_o: head <= head+1.
  - A pop while empty is ignored.
- Count update:
  - count += 1 on push only.
  - count -= 1 on pop only.
  - count unchanged when both or neither occur.
- Simultaneous push and pop with 0 < count < DEPTH: both occur and count is unchanged.
- Empty-queue case: push accepted, pop ignored, count becomes 1.
- Ordering: entries leave in strict FIFO order across pointer wrap-around (tail DEPTH-1 → 0).
- Throughput: one push and one pop per cycle sustained. Latency from push to head visibility is 1 cycle.

Decomposition:
- Shared defines header holds: `InstBus` [31:0], `AddrBus` [31:0], `Empty` 1'b1, `NotEmpty` 1'b0, `Enable`/`Disable`, and `Null` 0.
- Storage, pointers and flag logic stay in this module; a sub-module is not needed.
- An optional flag-generation helper, iq_ptr_ctrl, may hold pointer/count logic if reused by the LS queue.

Test Plan:
- Reset mid-operation: assert rst with 3 entries queued → iq_empty_o=1, inst_o=0, pc_o=0, bp_o=0 immediately (async); after release, first push appears at the head next cycle.
- Fill to full: push 16 entries with pc=0x00..0x3C and no pops → iq_full_o=1 after the 16th push; a 17th push (pc 0x40) is dropped. Draining then yields pc 0x00..0x3C in order and iq_empty_o=1 after the 16th pop.
- Wrap-around: push 12, pop 12, push 8 (pc 0x100..0x11C) → tail wraps; pops return 0x100..0x11C in order, and bp bits are preserved per entry.
- Simultaneous push/pop at count=5 → count stays 5; head advances and the new entry is appended. Simultaneous push/pop at count=0 → pop ignored, count=1, inst_o = pushed inst on the next cycle.
- clear with count=7 plus a concurrent push and pop → the next cycle has count=0, iq_empty_o=1, and the concurrent push is not stored. Repeat with rdy=0 → the flush still occurs.
- rdy=0 for 3 cycles with if_we_i=1 and id_re_i=1 → no state change and head outputs stable. After rdy returns to 1, normal push/pop resumes.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg
//   Shared bus widths, flag encodings and the entry layout used by the
//   instruction queue that sits between fetch and decode/issue.
//   Contents:
//     INST_W / ADDR_W      : instruction and address bus widths
//     EMPTY / NOT_EMPTY    : encodings of the empty flag
//     ENABLE / DISABLE     : generic write-enable encodings
//     NULL_INST / NULL_ADDR: value presented on the head outputs when idle
//     iq_entry_t           : one buffered {inst, pc, bp} entry
package inst_queue_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 32;

  localparam logic EMPTY     = 1'b1;
  localparam logic NOT_EMPTY = 1'b0;
  localparam logic ENABLE    = 1'b1;
  localparam logic DISABLE   = 1'b0;

  localparam logic [INST_W-1:0] NULL_INST = '0;
  localparam logic [ADDR_W-1:0] NULL_ADDR = '0;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              bp;
  } iq_entry_t;

  localparam int ENTRY_W = $bits(iq_entry_t);

endpackage

// File: rtl/inst_queue.sv
// inst_queue
//   Circular FIFO of fetched {inst, pc, bp} entries feeding the decode/issue
//   stage. The head entry is presented combinationally (show-ahead) so decode
//   can inspect it and pop it in the same cycle. A misprediction flushes the
//   whole queue through `clear`.
//   Ports:
//     clk, rst            : clock, asynchronous active-high reset
//     rdy                 : global ready; state freezes while low (clear still acts)
//     clear               : synchronous flush
//     if_we_i             : push request from fetch
//     if_inst_i/pc_i/bp_i : entry to push
//     iq_full_o           : queue holds DEPTH entries
//     id_re_i             : pop request from decode
//     inst_o/pc_o/bp_o    : head entry, zero while empty
//     iq_empty_o          : queue holds no entries
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              if_we_i,
  input  logic [INST_W-1:0] if_inst_i,
  input  logic [ADDR_W-1:0] if_pc_i,
  input  logic              if_bp_i,
  output logic              iq_full_o,
  input  logic              id_re_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              bp_o,
  output logic              iq_empty_o
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic      pushAccept;
  logic      popAccept;
  logic      memWe;
  iq_entry_t headEntry;
  iq_entry_t pushEntry;

  // Flags come straight from the occupancy count so they are valid the same
  // cycle the count settles, with no extra pipeline stage.
  always_comb begin
    iq_empty_o = (count_q == '0) ? EMPTY : NOT_EMPTY;
    iq_full_o  = (count_q == CNT_DEPTH);
  end

  // Acceptance is decided from the pre-edge flags: a push into a full queue is
  // dropped even if a pop frees a slot in the same cycle, and a pop of an
  // empty queue is ignored even if a push arrives with it.
  always_comb begin
    pushAccept = if_we_i && !iq_full_o;
    popAccept  = id_re_i && (iq_empty_o == NOT_EMPTY);
  end

  // Show-ahead head outputs. There is no bypass from the push port, so a new
  // entry only appears here once it has been written into storage.
  always_comb begin
    headEntry = mem_q[head_q];
    if (iq_empty_o == EMPTY) begin
      inst_o = NULL_INST;
      pc_o   = NULL_ADDR;
      bp_o   = 1'b0;
    end else begin
      inst_o = headEntry.inst;
      pc_o   = headEntry.pc;
      bp_o   = headEntry.bp;
    end
  end

  // Pointer and count next state. clear outranks rdy so a flush still lands
  // while the pipeline is otherwise stalled.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    memWe   = DISABLE;
    if (clear) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy) begin
      if (pushAccept) begin
        tail_d = tail_q + PTR_ONE;
        memWe  = ENABLE;
      end
      if (popAccept) begin
        head_d = head_q + PTR_ONE;
      end
      unique case ({pushAccept, popAccept})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left unreset; the count guards every read.
  always_comb begin
    pushEntry.inst = if_inst_i;
    pushEntry.pc   = if_pc_i;
    pushEntry.bp   = if_bp_i;
  end

  always_ff @(posedge clk) begin
    if (memWe == ENABLE) begin
      mem_q[tail_q] <= pushEntry;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue
//   Directed bench for inst_queue. A queue-based reference model tracks the
//   expected contents; every negative clock edge the flags and head outputs
//   are compared against it. Directed sequences add literal expectations.
module tb_inst_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        clear;
  logic        if_we_i;
  logic [31:0] if_inst_i;
  logic [31:0] if_pc_i;
  logic        if_bp_i;
  logic        iq_full_o;
  logic        id_re_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        bp_o;
  logic        iq_empty_o;

  int total = 0;
  int bad   = 0;
  bit cmpEn = 1'b0;

  logic [64:0] mdl[$];

  inst_queue #(.DEPTH(16), .PTR_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .clear      (clear),
    .if_we_i    (if_we_i),
    .if_inst_i  (if_inst_i),
    .if_pc_i    (if_pc_i),
    .if_bp_i    (if_bp_i),
    .iq_full_o  (iq_full_o),
    .id_re_i    (id_re_i),
    .inst_o     (inst_o),
    .pc_o       (pc_o),
    .bp_o       (bp_o),
    .iq_empty_o (iq_empty_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instOf(input logic [31:0] pc);
    return 32'hC0DE_0000 ^ {pc[15:0], pc[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [64:0] act,
                             input logic [64:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model.
  task automatic applyStimulus(input bit we, input bit re, input bit clr,
                               input bit rd, input logic [31:0] pc,
                               input bit bp);
    bit pushOk;
    bit popOk;
    if_we_i   = we;
    id_re_i   = re;
    clear     = clr;
    rdy       = rd;
    if_pc_i   = pc;
    if_inst_i = instOf(pc);
    if_bp_i   = bp;
    @(posedge clk);
    if (clr) begin
      mdl.delete();
    end else if (rd) begin
      pushOk = we && (mdl.size() < 16);
      popOk  = re && (mdl.size() > 0);
      if (popOk) void'(mdl.pop_front());
      if (pushOk) mdl.push_back({instOf(pc), pc, bp});
    end
    #1;
    if_we_i = 1'b0;
    id_re_i = 1'b0;
    clear   = 1'b0;
    rdy     = 1'b1;
  endtask

  task automatic pushOne(input logic [31:0] pc, input bit bp);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, pc, bp);
  endtask

  task automatic popOne();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b0);
  endtask

  // Per-cycle comparison against the reference model.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("cyc_empty", 65'(iq_empty_o), 65'(mdl.size() == 0));
      checkOutput("cyc_full",  65'(iq_full_o),  65'(mdl.size() == 16));
      if (mdl.size() == 0) begin
        checkOutput("cyc_head", {inst_o, pc_o, bp_o}, 65'h0);
      end else begin
        checkOutput("cyc_head", {inst_o, pc_o, bp_o}, mdl[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; clear = 1'b0; if_we_i = 1'b0; id_re_i = 1'b0;
    if_inst_i = '0; if_pc_i = '0; if_bp_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_empty", 65'(iq_empty_o), 65'h1);
    checkOutput("rst_full",  65'(iq_full_o),  65'h0);
    checkOutput("rst_head",  {inst_o, pc_o, bp_o}, 65'h0);
    rst = 1'b0;
    cmpEn = 1'b1;

    // Reset mid-operation
    for (int i = 0; i < 3; i++) pushOne(32'h10 + 32'(i * 4), 1'b1);
    checkOutput("pre_rst_pc", 65'(pc_o), 65'h10);
    #2;
    rst = 1'b1;
    mdl.delete();
    #1;
    checkOutput("arst_empty", 65'(iq_empty_o), 65'h1);
    checkOutput("arst_head",  {inst_o, pc_o, bp_o}, 65'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pushOne(32'h200, 1'b1);
    checkOutput("post_rst_pc",   65'(pc_o),   65'h200);
    checkOutput("post_rst_inst", 65'(inst_o), 65'(instOf(32'h200)));
    popOne();

    // Fill to full, then drain
    for (int i = 0; i < 16; i++) pushOne(32'(i * 4), i[0]);
    checkOutput("fill_full", 65'(iq_full_o), 65'h1);
    pushOne(32'h40, 1'b1);
    checkOutput("fill_drop_full", 65'(iq_full_o), 65'h1);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drain_pc", 65'(pc_o), 65'(i * 4));
      checkOutput("drain_bp", 65'(bp_o), 65'(i % 2));
      popOne();
    end
    checkOutput("drain_empty", 65'(iq_empty_o), 65'h1);

    // Wrap-around
    for (int i = 0; i < 12; i++) pushOne(32'h300 + 32'(i * 4), 1'b0);
    for (int i = 0; i < 12; i++) popOne();
    for (int i = 0; i < 8; i++) pushOne(32'h100 + 32'(i * 4), (i % 3) == 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wrap_pc", 65'(pc_o), 65'(32'h100 + i * 4));
      checkOutput("wrap_bp", 65'(bp_o), 65'((i % 3) == 0));
      popOne();
    end
    checkOutput("wrap_empty", 65'(iq_empty_o), 65'h1);

    // Simultaneous push/pop at count 5, then at count 0
    for (int i = 0; i < 5; i++) pushOne(32'h400 + 32'(i * 4), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h500, 1'b1);
    checkOutput("pp5_head", 65'(pc_o), 65'h404);
    for (int i = 0; i < 4; i++) begin
      checkOutput("pp5_seq", 65'(pc_o), 65'(32'h404 + i * 4));
      popOne();
    end
    checkOutput("pp5_tail_pc", 65'(pc_o), 65'h500);
    checkOutput("pp5_tail_bp", 65'(bp_o), 65'h1);
    popOne();
    checkOutput("pp5_empty", 65'(iq_empty_o), 65'h1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 1'b0);
    checkOutput("pp0_empty", 65'(iq_empty_o), 65'h0);
    checkOutput("pp0_inst",  65'(inst_o), 65'(instOf(32'h600)));
    popOne();
    checkOutput("pp0_count1", 65'(iq_empty_o), 65'h1);

    // Clear with concurrent push/pop, with rdy high then low
    for (int i = 0; i < 7; i++) pushOne(32'h700 + 32'(i * 4), 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 32'h7F0, 1'b1);
    checkOutput("clr_empty", 65'(iq_empty_o), 65'h1);
    checkOutput("clr_head",  {inst_o, pc_o, bp_o}, 65'h0);
    for (int i = 0; i < 7; i++) pushOne(32'h780 + 32'(i * 4), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h7F4, 1'b1);
    checkOutput("clr_rdy0_empty", 65'(iq_empty_o), 65'h1);
    pushOne(32'h7A0, 1'b0);
    checkOutput("clr_after_pc", 65'(pc_o), 65'h7A0);
    popOne();

    // rdy low freezes everything
    for (int i = 0; i < 3; i++) pushOne(32'h800 + 32'(i * 4), 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h8F0, 1'b0);
      checkOutput("stall_pc", 65'(pc_o), 65'h800);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h900, 1'b0);
    checkOutput("resume_pc", 65'(pc_o), 65'h804);
    popOne();
    popOne();
    checkOutput("resume_last", 65'(pc_o), 65'h900);
    popOne();
    checkOutput("resume_empty", 65'(iq_empty_o), 65'h1);

    @(negedge clk);
    cmpEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
